// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN window fetch engine.
// Holds the fetch FSM encoding and window geometry constants.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int WIN_TAPS   = 9;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/cnn_win_addr.sv
// Tap coordinate, bounds check and byte address for one 3x3 window tap.
// Ports: base/img dims/centre/tap in; in_range_o and addr_o out.
module cnn_win_addr
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 9
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [DIM_W-1:0]  img_w_i,
  input  logic [DIM_W-1:0]  img_h_i,
  input  logic [DIM_W-1:0]  row_i,
  input  logic [DIM_W-1:0]  col_i,
  input  logic [3:0]        tap_i,
  output logic              in_range_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic signed [DIM_W:0] M1 = '1;
  localparam logic signed [DIM_W:0] Z0 = '0;
  localparam logic signed [DIM_W:0] P1 = (DIM_W+1)'(1);

  logic signed [DIM_W:0] dr, dc;
  logic signed [DIM_W:0] r, c;
  logic                  r_ok, c_ok;
  logic [2*DIM_W-1:0]    prod;
  logic [ADDR_W-1:0]     idx;

  always_comb begin
    dr = P1;
    dc = P1;
    case (tap_i)
      4'd0, 4'd1, 4'd2: dr = M1;
      4'd3, 4'd4, 4'd5: dr = Z0;
      default:          dr = P1;
    endcase
    case (tap_i)
      4'd0, 4'd3, 4'd6: dc = M1;
      4'd1, 4'd4, 4'd7: dc = Z0;
      default:          dc = P1;
    endcase
  end

  assign r = $signed({1'b0, row_i}) + dr;
  assign c = $signed({1'b0, col_i}) + dc;

  // Sign bit set means the tap fell off the top/left edge.
  assign r_ok = !r[DIM_W] && (r[DIM_W-1:0] < img_h_i);
  assign c_ok = !c[DIM_W] && (c[DIM_W-1:0] < img_w_i);
  assign in_range_o = r_ok && c_ok;

  assign prod = {{DIM_W{1'b0}}, r[DIM_W-1:0]}
              * {{DIM_W{1'b0}}, img_w_i};
  assign idx  = ADDR_W'(prod) + ADDR_W'(c[DIM_W-1:0]);
  assign addr_o = base_i + (idx << WORD_SHIFT);

endmodule

// File: rtl/cnn_window_fetch.sv
// Fetches a zero-padded 3x3 window over a single-word read port.
// Ports: start/geometry in, mem request/response, win valid/ready beat out.
module cnn_window_fetch
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 9
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [DIM_W-1:0]           img_w,
  input  logic [DIM_W-1:0]           img_h,
  input  logic [DIM_W-1:0]           row,
  input  logic [DIM_W-1:0]           col,
  output logic                       busy,
  output logic                       mem_valid,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [WIN_TAPS*DATA_W-1:0] win_data
);

  state_e state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIN_TAPS*DATA_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0] w_q, h_q, row_q, col_q;
  logic ld;
  logic tap_ok;
  logic [ADDR_W-1:0] tap_addr;

  cnn_win_addr #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr (
    .base_i     (base_q),
    .img_w_i    (w_q),
    .img_h_i    (h_q),
    .row_i      (row_q),
    .col_i      (col_q),
    .tap_i      (k_q),
    .in_range_o (tap_ok),
    .addr_o     (tap_addr)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      win_q   <= '0;
      base_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      if (ld) begin
        base_q <= base_addr;
        w_q    <= img_w;
        h_q    <= img_h;
        row_q  <= row;
        col_q  <= col;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    win_d   = win_q;
    ld      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ld      = 1'b1;
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (tap_ok) begin
          addr_d  = tap_addr;
          state_d = S_ISSUE;
        end else begin
          win_d[DATA_W*k_q +: DATA_W] = '0;
          state_d = S_NEXT;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ready) begin
          win_d[DATA_W*k_q +: DATA_W] = mem_rdata;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (k_q == 4'(WIN_TAPS-1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (win_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_valid = (state_q == S_ISSUE);
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  assign mem_addr  = addr_q;
  assign win_valid = (state_q == S_DONE);
  assign win_data  = win_q;

endmodule

// File: tb/tb_cnn_window_fetch.sv
// Directed bench for cnn_window_fetch with a latency-programmable memory.
// Scenario tasks check their own results inline and feed one summary.
module tb_cnn_window_fetch;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [8:0]   img_w = 9'd1;
  logic [8:0]   img_h = 9'd1;
  logic [8:0]   row = '0;
  logic [8:0]   col = '0;
  logic         busy;
  logic         mem_valid;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         win_valid;
  logic         win_ready = 1'b1;
  logic [287:0] win_data;

  int vec = 0;
  int err = 0;

  int          lat = 1;
  bit          inject = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] rd_q[$];

  cnn_window_fetch #(
    .ADDR_W (32),
    .DATA_W (32),
    .DIM_W  (9)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .img_w     (img_w),
    .img_h     (img_h),
    .row       (row),
    .col       (col),
    .busy      (busy),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  function automatic logic [287:0] exp_win(
    input logic [31:0] b, input int w, input int h,
    input int r, input int c);
    logic [287:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      int rr;
      int cc;
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < h && cc >= 0 && cc < w)
        v[32*k +: 32] = mem_word(b + 32'((rr * w + cc) * 4));
    end
    return v;
  endfunction

  // Memory model: answers lat cycles after each request; optional
  // bogus strobe during the request cycle itself.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_0000;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(pend_addr);
      end
    end
    if (mem_valid === 1'b1) begin
      rd_q.push_back(mem_addr);
      pend_addr = mem_addr;
      cnt = lat;
      if (inject) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input int w,
                          input int h, input int r, input int c);
    @(negedge clk);
    base_addr = b;
    img_w = 9'(w);
    img_h = 9'(h);
    row = 9'(r);
    col = 9'(c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 32'hFFFF_FFFC;
    img_w = 9'd1;
    img_h = 9'd1;
    row = '0;
    col = '0;
  endtask

  task automatic wait_win(output int n);
    n = 1;
    while (win_valid !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({busy, mem_valid, win_valid, mem_write} !== 4'b0000) begin
      err++;
      $display("FAIL reset_flags got=%b want=0000",
               {busy, mem_valid, win_valid, mem_write});
    end
    vec++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      err++;
      $display("FAIL reset_addr got=%h/%h want=0/0", mem_addr, mem_wdata);
    end
    vec++;
    if (win_data !== 288'h0) begin
      err++;
      $display("FAIL reset_win got=%h want=0", win_data);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_interior();
    int n;
    logic [287:0] e;
    rd_q.delete();
    e = exp_win(32'h10000, 224, 224, 5, 7);
    do_start(32'h10000, 224, 224, 5, 7);
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || n != 37) begin
      err++;
      $display("FAIL int_latency got=%0d want=37 (valid=%b)", n, win_valid);
    end
    vec++;
    if (rd_q.size() != 9) begin
      err++;
      $display("FAIL int_reads got=%0d want=9", rd_q.size());
    end else begin
      vec++;
      if (rd_q[0] !== 32'h10E18 || rd_q[8] !== 32'h11520) begin
        err++;
        $display("FAIL int_addr got=%h..%h want=00010e18..00011520",
                 rd_q[0], rd_q[8]);
      end
    end
    vec++;
    if (win_data !== e) begin
      err++;
      $display("FAIL int_data got=%h want=%h", win_data, e);
    end
    @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0 || win_valid !== 1'b0) begin
      err++;
      $display("FAIL int_release got=%b%b want=00", busy, win_valid);
    end
  endtask

  task automatic test_corner();
    int n;
    logic [287:0] e;
    logic [31:0] ea[4];
    ea[0] = 32'h10000;
    ea[1] = 32'h10004;
    ea[2] = 32'h10380;
    ea[3] = 32'h10384;
    rd_q.delete();
    e = exp_win(32'h10000, 224, 224, 0, 0);
    do_start(32'h10000, 224, 224, 0, 0);
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || n != 27) begin
      err++;
      $display("FAIL corner_latency got=%0d want=27", n);
    end
    vec++;
    if (rd_q.size() != 4) begin
      err++;
      $display("FAIL corner_reads got=%0d want=4", rd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vec++;
        if (rd_q[i] !== ea[i]) begin
          err++;
          $display("FAIL corner_addr%0d got=%h want=%h", i, rd_q[i], ea[i]);
        end
      end
    end
    vec++;
    if (win_data[0 +: 128] !== 128'h0 || win_data[192 +: 32] !== 32'h0) begin
      err++;
      $display("FAIL corner_pad got=%h want=zeros", win_data);
    end
    vec++;
    if (win_data !== e) begin
      err++;
      $display("FAIL corner_data got=%h want=%h", win_data, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_px();
    int n;
    logic [287:0] e;
    e = '0;
    e[128 +: 32] = 32'hE3C3_0F0F;
    rd_q.delete();
    do_start(32'h2000, 1, 1, 0, 0);
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || n != 21) begin
      err++;
      $display("FAIL onepx_latency got=%0d want=21", n);
    end
    vec++;
    if (rd_q.size() != 1 || rd_q[0] !== 32'h2000) begin
      err++;
      $display("FAIL onepx_reads got=%0d want=1 at 00002000", rd_q.size());
    end
    vec++;
    if (win_data !== e) begin
      err++;
      $display("FAIL onepx_data got=%h want=%h", win_data, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_slow_mem();
    int n;
    logic [287:0] e;
    rd_q.delete();
    lat = 5;
    inject = 1'b1;
    e = exp_win(32'h400, 4, 3, 1, 1);
    do_start(32'h400, 4, 3, 1, 1);
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || n != 73) begin
      err++;
      $display("FAIL slow_latency got=%0d want=73", n);
    end
    vec++;
    if (rd_q.size() != 9) begin
      err++;
      $display("FAIL slow_reads got=%0d want=9", rd_q.size());
    end
    vec++;
    if (win_data !== e) begin
      err++;
      $display("FAIL slow_data got=%h want=%h", win_data, e);
    end
    @(posedge clk);
    #1;
    lat = 1;
    inject = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [287:0] e;
    logic [287:0] e2;
    rd_q.delete();
    win_ready = 1'b0;
    e = exp_win(32'h10000, 224, 224, 100, 100);
    do_start(32'h10000, 224, 224, 100, 100);
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || win_data !== e) begin
      err++;
      $display("FAIL bp_data got=%h want=%h", win_data, e);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 5);
      row = 9'd3;
      col = 9'd3;
      @(posedge clk);
      #1;
      vec++;
      if (win_valid !== 1'b1 || busy !== 1'b1 || win_data !== e) begin
        err++;
        $display("FAIL bp_hold%0d got=%b%b %h want=11 %h",
                 i, win_valid, busy, win_data, e);
      end
    end
    start = 1'b0;
    vec++;
    if (rd_q.size() != 9) begin
      err++;
      $display("FAIL bp_no_new_reads got=%0d want=9", rd_q.size());
    end
    @(negedge clk);
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0 || win_valid !== 1'b0) begin
      err++;
      $display("FAIL bp_release got=%b%b want=00", busy, win_valid);
    end
    rd_q.delete();
    e2 = exp_win(32'h8000, 16, 16, 15, 15);
    do_start(32'h8000, 16, 16, 15, 15);
    vec++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL bp_restart got=%b want=1", busy);
    end
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || n != 27 || rd_q.size() != 4) begin
      err++;
      $display("FAIL brcorner_timing got=%0d/%0d want=27/4", n, rd_q.size());
    end
    vec++;
    if (win_data !== e2) begin
      err++;
      $display("FAIL brcorner_data got=%h want=%h", win_data, e2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int t;
    int n;
    bit bad;
    logic [287:0] e;
    rd_q.delete();
    lat = 5;
    do_start(32'h10000, 224, 224, 5, 7);
    t = 0;
    while (rd_q.size() < 4 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    vec++;
    if (rd_q.size() != 4) begin
      err++;
      $display("FAIL rst_reach got=%0d want=4", rd_q.size());
    end
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    vec++;
    if ({busy, mem_valid, win_valid} !== 3'b000 || mem_addr !== 32'h0 ||
        win_data !== 288'h0) begin
      err++;
      $display("FAIL rst_mid got=%b%b%b %h want=000 0",
               busy, mem_valid, win_valid, mem_addr);
    end
    @(negedge clk);
    resetn = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || mem_valid !== 1'b0 || win_valid !== 1'b0)
        bad = 1'b1;
    end
    vec++;
    if (bad || rd_q.size() != 4) begin
      err++;
      $display("FAIL rst_stale got=%b/%0d want=0/4", bad, rd_q.size());
    end
    lat = 1;
    rd_q.delete();
    e = exp_win(32'h10000, 224, 224, 5, 7);
    do_start(32'h10000, 224, 224, 5, 7);
    wait_win(n);
    vec++;
    if (win_valid !== 1'b1 || n != 37 || win_data !== e) begin
      err++;
      $display("FAIL rst_refetch got=%0d %h want=37 %h", n, win_data, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_interior();
    test_corner();
    test_one_px();
    test_slow_mem();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/cnn_window_fetch.md
Name: cnn_window_fetch

Overview:
- Fetch engine feeding the convolution datapath inside the CNN PCPI coprocessor.
- Given a feature-map base address, dimensions and a centre pixel, reads the 3x3 neighbourhood over the coprocessor's single-word memory port.
- Out-of-image positions are zero-padded without issuing memory accesses.
- Presents the 9 words as one wide beat on a valid/ready output.

Parameters:
- ADDR_W, 32, byte address width of the memory port.
- DATA_W, 32, word width of the memory port and of each window element.
- DIM_W, 9, width of image width/height and row/col coordinates (max 511).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to fetch a window; sampled only while busy=0
- base_addr  in  ADDR_W  byte address of pixel (0,0); word-aligned
- img_w  in  DIM_W  image width in pixels, >=1
- img_h  in  DIM_W  image height in pixels, >=1
- row  in  DIM_W  centre row, < img_h
- col  in  DIM_W  centre column, < img_w
- busy  out  1  high from start acceptance until the output beat is consumed
- mem_valid  out  1  one-cycle read request pulse
- mem_write  out  1  tied 0 (read-only engine)
- mem_addr  out  ADDR_W  byte address, valid while mem_valid=1
- mem_wdata  out  DATA_W  tied 0
- mem_ready  in  1  response strobe; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  read data
- win_valid  out  1  window beat available
- win_ready  in  1  consumer accepts the beat
- win_data  out  9*DATA_W  element k at [DATA_W*k +: DATA_W], k = 3*(dr+1)+(dc+1), dr,dc in {-1,0,1}

Behaviour:
- Reset values: busy=0, mem_valid=0, mem_addr=0, win_valid=0, win_data=0, state IDLE.
- Inputs are latched on start acceptance; later changes have no effect on the fetch in progress.
- States:
  - IDLE: on start, latch inputs, k=0, go to CALC.
  - CALC: compute r=row+dr, c=col+dc as signed DIM_W+1. If r<0, r>=img_h, c<0 or c>=img_w, clear element k and go to NEXT. Otherwise mem_addr = base_addr + ((r*img_w + c) << 2), truncated to ADDR_W, and go to ISSUE.
  - ISSUE: mem_valid=1 for exactly one cycle, then WAIT.
  - WAIT: mem_valid=0; when mem_ready=1, store mem_rdata into element k and go to NEXT. Waits indefinitely; there is no timeout.
  - NEXT: if k=8 go to DONE, else k++ and go to CALC.
  - DONE: win_valid=1 and win_data held stable until win_ready=1; on that cycle go to IDLE with win_valid=0 and busy=0 on the next cycle.
- mem_ready is ignored in every state except WAIT; a stale strobe after reset or abort is discarded.
- Latency per element: 4 cycles for an in-image element when memory answers 1 cycle after mem_valid; 2 cycles for a padded element.
- Interior window with 1-cycle memory: start cycle to win_valid is 1+9*4 = 37 cycles.
- start while busy=1 is ignored; no queueing.
- win_ready while win_valid=0 is ignored.
- Reset mid-fetch: next cycle all outputs take reset values, partial window discarded, no further mem_valid.
- Multiply is DIM_W x DIM_W unsigned; the product fits in 2*DIM_W bits and is zero-extended before the add.

Decomposition:
- Shared package cnn_pkg holds:
  - fsm state encoding (IDLE, CALC, ISSUE, WAIT, NEXT, DONE)
  - WIN_TAPS=9
  - WORD_SHIFT=2
- Sub-module cnn_win_addr (combinational): coordinate offset, bounds check and address computation. Outputs in_range and addr; unit-testable on its own.

Test Plan:
- Interior window: base 0x10000, img_w=img_h=224, row=5, col=7. Expect 9 reads; first address 0x10000+(4*224+6)*4=0x10E18, last 0x10000+(6*224+8)*4=0x11520. win_data equals the memory words; beat arrives 37 cycles after start.
- Corner (0,0), 224x224: exactly 4 reads (0x10000, 0x10004, 0x10380, 0x10384). Elements 0,1,2,3,6 = 0; elements 4,5,7,8 equal memory.
- 1x1 image, row=col=0: single read at base_addr; element 4 = memory word; other 8 elements zero; 1+8*2+4 = 21 cycles.
- Memory responds 5 cycles after mem_valid, with an extra mem_ready strobe injected in ISSUE: the extra strobe is ignored. Each element is stored from the WAIT-state strobe only. Exactly one mem_valid pulse per in-image element.
- Back-pressure: hold win_ready=0 for 20 cycles after win_valid. win_data stays stable and busy=1; a start pulse meanwhile is ignored. Release win_ready: busy drops next cycle, and a new start is then accepted.
- Reset mid-fetch: assert resetn=0 during the WAIT for element 3, then release. All outputs are at reset values, a late mem_ready causes nothing, and a following start produces a correct full window.
